// File: rtl/viterbi_pkg.sv
// Shared types and sizing helpers for the Viterbi metric/traceback controller.
package viterbi_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_TRACE = 2'd1,
        ST_EMIT  = 2'd2
    } vtb_state_e;

    function automatic int calc_s(input int k);
        return 1 << (k - 1);
    endfunction

    function automatic int calc_m(input int t, input int d);
        return t + d;
    endfunction

    function automatic int calc_lg(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // State 0 starts at zero, every other state starts at the saturated maximum.
    function automatic logic [1023:0] init_metrics(input int s, input int w);
        logic [1023:0] v;
        v = '0;
        for (int i = 1; i < s; i++) begin
            for (int b = 0; b < w; b++) begin
                v[i*w+b] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/viterbi_min_state.sv
// Combinational compare tree returning the smallest metric and its index (lowest index on ties).
module viterbi_min_state
    import viterbi_pkg::*;
#(
    parameter int S = 4,
    parameter int W = 4,
    localparam int LS = calc_lg(S)
) (
    input  logic [S*W-1:0] metrics,
    output logic [LS-1:0]  min_idx,
    output logic [W-1:0]   min_val
);

    logic [W-1:0]  nv [2*S-1];
    logic [LS-1:0] ni [2*S-1];

    // Heap layout: leaves at S-1..2S-2 in state order, so a left child always covers lower indices.
    always_comb begin
        for (int i = 0; i < S; i++) begin
            nv[S-1+i] = metrics[i*W +: W];
            ni[S-1+i] = LS'(i);
        end
        for (int n = S - 2; n >= 0; n--) begin
            if (nv[2*n+2] < nv[2*n+1]) begin
                nv[n] = nv[2*n+2];
                ni[n] = ni[2*n+2];
            end else begin
                nv[n] = nv[2*n+1];
                ni[n] = ni[2*n+1];
            end
        end
        min_val = nv[0];
        min_idx = ni[0];
    end

endmodule

// File: rtl/viterbi_tb_ctrl.sv
// Viterbi state-metric holder, survivor memory and traceback/emit sequencer.
// Optional metric normalisation is enabled by defining VTB_NORM_EN.
module viterbi_tb_ctrl
    import viterbi_pkg::*;
#(
    parameter int K       = 3,
    parameter int W       = 4,
    parameter int T       = 8,
    parameter int D       = 4,
    parameter int NFRAMES = 64,
    parameter int ERR_TH  = 12,
    localparam int S      = calc_s(K)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [S*W-1:0] a_in,
    input  logic [S-1:0]   p_in,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [S*W-1:0] a_out,
    output logic           tb_en,
    output logic           dx,
    output logic           dx_valid,
    output logic           error
);

    localparam int M  = calc_m(T, D);
    localparam int LS = calc_lg(S);
    localparam int PW = calc_lg(M);
    localparam int CW = $clog2(M + 1);
    localparam int FW = $clog2(NFRAMES + 1);
    localparam logic [S*W-1:0] INIT_A = (S*W)'(init_metrics(S, W));
    localparam logic [31:0]    ERR_TH_V = ERR_TH;

    vtb_state_e     state_q, state_d;
    logic [S*W-1:0] a_q, a_d;
    logic [S-1:0]   mem_q [M];
    logic [S-1:0]   mem_d [M];
    logic [PW-1:0]  wr_q, wr_d;
    logic [PW-1:0]  rd_q, rd_d;
    logic [CW-1:0]  fill_q, fill_d;
    logic [CW-1:0]  step_q, step_d;
    logic [FW-1:0]  frame_q, frame_d;
    logic [LS-1:0]  s_q, s_d;
    logic [D-1:0]   obuf_q, obuf_d;
    logic           err_q, err_d;

    logic [S*W-1:0] a_norm;
    logic [LS-1:0]  min_idx;
    logic [W-1:0]   min_val;

`ifdef VTB_NORM_EN
    logic all_msb;

    always_comb begin
        a_norm  = a_in;
        all_msb = 1'b1;
        for (int i = 0; i < S; i++) begin
            all_msb = all_msb & a_in[i*W+W-1];
        end
        if (all_msb) begin
            for (int i = 0; i < S; i++) begin
                a_norm[i*W+W-1] = 1'b0;
            end
        end
    end
`else
    always_comb begin
        a_norm = a_in;
    end
`endif

    // Evaluated on the incoming column so the start state and sync check are ready at TRACE entry.
    viterbi_min_state #(.S(S), .W(W)) u_min (
        .metrics (a_norm),
        .min_idx (min_idx),
        .min_val (min_val)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        fill_d  = fill_q;
        step_d  = step_q;
        frame_d = frame_q;
        s_d     = s_q;
        obuf_d  = obuf_q;
        err_d   = err_q;
        case (state_q)
            ST_FILL: begin
                if (in_valid) begin
                    a_d        = a_norm;
                    mem_d[wr_q] = p_in;
                    wr_d       = (wr_q == PW'(M - 1)) ? '0 : wr_q + PW'(1);
                    if (fill_q == CW'(1)) begin
                        fill_d  = CW'(D);
                        state_d = ST_TRACE;
                        rd_d    = wr_q;
                        s_d     = min_idx;
                        step_d  = CW'(M - 1);
                        if ({{(32-W){1'b0}}, min_val} > ERR_TH_V) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        fill_d = fill_q - CW'(1);
                    end
                end
            end
            ST_TRACE: begin
                s_d  = (s_q >> 1) | (LS'(mem_q[rd_q][s_q]) << (K - 2));
                rd_d = (rd_q == '0) ? PW'(M - 1) : rd_q - PW'(1);
                // Only the last D steps (oldest columns) reach the output buffer.
                if (step_q < CW'(D)) begin
                    obuf_d = (obuf_q << 1) | D'(s_q[0]);
                end
                if (step_q == '0) begin
                    state_d = ST_EMIT;
                    step_d  = CW'(D - 1);
                end else begin
                    step_d = step_q - CW'(1);
                end
            end
            ST_EMIT: begin
                obuf_d = obuf_q >> 1;
                if (step_q == '0) begin
                    state_d = ST_FILL;
                    if (frame_q == FW'(NFRAMES - 1)) begin
                        a_d     = INIT_A;
                        wr_d    = '0;
                        fill_d  = CW'(M);
                        frame_d = '0;
                    end else begin
                        frame_d = frame_q + FW'(1);
                    end
                end else begin
                    step_d = step_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_FILL;
            a_q     <= INIT_A;
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            fill_q  <= CW'(M);
            step_q  <= '0;
            frame_q <= '0;
            s_q     <= '0;
            obuf_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            fill_q  <= fill_d;
            step_q  <= step_d;
            frame_q <= frame_d;
            s_q     <= s_d;
            obuf_q  <= obuf_d;
            err_q   <= err_d;
        end
    end

    assign a_out    = a_q;
    assign in_ready = (state_q == ST_FILL);
    assign tb_en    = (state_q == ST_TRACE);
    assign dx_valid = (state_q == ST_EMIT);
    assign dx       = dx_valid & obuf_q[0];
    assign error    = err_q;

endmodule

// File: tb/tb_viterbi_tb_ctrl.sv
// Directed bench for viterbi_tb_ctrl: decoded bits go through a scoreboard queue, control timing checked inline.
module tb_viterbi_tb_ctrl;

    localparam int M = 12;
    localparam int D = 4;

`ifdef VTB_NORM_EN
    localparam logic [15:0] EXP_NORM = 16'h7421;
    localparam logic        EXP_ERR  = 1'b0;
`else
    localparam logic [15:0] EXP_NORM = 16'hFCA9;
    localparam logic        EXP_ERR  = 1'b1;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] a_in = '0;
    logic [3:0]  p_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a_out;
    logic        tb_en;
    logic        dx;
    logic        dx_valid;
    logic        error;

    int nvec = 0;
    int nerr = 0;
    bit exp_q[$];
    logic [1:0] enc_s;
    bit ubits [16] = '{1,0,1,1, 0,0,1,0, 1,1,0,1, 0,0,0,0};

    viterbi_tb_ctrl #(
        .K(3), .W(4), .T(8), .D(4), .NFRAMES(2), .ERR_TH(12)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .a_in     (a_in),
        .p_in     (p_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_out    (a_out),
        .tb_en    (tb_en),
        .dx       (dx),
        .dx_valid (dx_valid),
        .error    (error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic send_col(input logic [15:0] a, input logic [3:0] p);
        int guard;
        guard = 0;
        a_in = a;
        p_in = p;
        in_valid = 1'b1;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Called in the first cycle after a triggering accept; walks TRACE and EMIT.
    task automatic frame_timing(input string name);
        logic [15:0] a0;
        int bad;
        a0 = a_out;
        bad = 0;
        for (int i = 0; i < M; i++) begin
            if (!(tb_en === 1'b1 && in_ready === 1'b0 && dx_valid === 1'b0 && a_out === a0)) bad++;
            tick();
        end
        for (int i = 0; i < D; i++) begin
            if (!(tb_en === 1'b0 && in_ready === 1'b0 && dx_valid === 1'b1 && a_out === a0)) bad++;
            tick();
        end
        chk({name, "_timing"}, bad, 0);
        chk({name, "_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    // Noiseless encoder: state holds last two inputs, newest at LSB; only the true state gets a decision.
    task automatic enc_col(input bit u, output logic [15:0] a, output logic [3:0] p);
        logic [1:0] s_new;
        s_new = {enc_s[0], u};
        p = 4'(enc_s[1]) << s_new;
        for (int i = 0; i < 4; i++) a[i*4 +: 4] = (i == int'(s_new)) ? 4'd1 : 4'd6;
        enc_s = s_new;
    endtask

    task automatic push_zeros();
        for (int j = 0; j < D; j++) exp_q.push_back(1'b0);
    endtask

    always @(negedge clock) begin
        if (dx_valid) begin
            if (exp_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL sb_unexpected: dx=%0b with no expected bit queued", dx);
            end else begin
                chk("sb_dx", {31'd0, dx}, {31'd0, exp_q.pop_front()});
                chk("sb_excl", {31'd0, tb_en}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] a, a12;
        logic [3:0]  p, p12;

        do_reset();
        chk("rst_a_out", a_out, 16'hFFF0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_tb_en", tb_en, 0);
        chk("rst_dx_valid", dx_valid, 0);
        chk("rst_dx", dx, 0);
        chk("rst_error", error, 0);

        // All-zero decisions from state 0 decode as zeros.
        for (int c = 0; c < 11; c++) send_col(16'hFFF0, 4'h0);
        chk("zero_fill11", {tb_en, in_ready}, 2'b01);
        push_zeros();
        send_col(16'hFFF0, 4'h0);
        frame_timing("zero");

        do_reset();
        send_col(16'hFCA9, 4'h0);
        chk("norm_all_msb", a_out, EXP_NORM);
        send_col(16'hFCA1, 4'h0);
        chk("norm_mixed_msb", a_out, 16'hFCA1);

        // Encoder stream, column 12 held valid through TRACE/EMIT, then block re-init.
        do_reset();
        enc_s = 2'b00;
        for (int c = 0; c < 12; c++) begin
            if (c == 11) for (int j = 0; j < 4; j++) exp_q.push_back(ubits[j]);
            enc_col(ubits[c], a, p);
            send_col(a, p);
        end
        enc_col(ubits[12], a12, p12);
        a_in = a12;
        p_in = p12;
        in_valid = 1'b1;
        frame_timing("enc_f1");
        send_col(a12, p12);
        chk("hold_accept", a_out, a12);
        for (int c = 13; c < 16; c++) begin
            if (c == 15) for (int j = 4; j < 8; j++) exp_q.push_back(ubits[j]);
            enc_col(ubits[c], a, p);
            send_col(a, p);
        end
        frame_timing("enc_f2");
        chk("block_reinit", a_out, 16'hFFF0);
        for (int c = 0; c < 11; c++) send_col(16'hFFF0, 4'h0);
        chk("reinit_fill11", {tb_en, in_ready}, 2'b01);
        push_zeros();
        send_col(16'hFFF0, 4'h0);
        frame_timing("reinit");

        // Reset in the middle of TRACE discards the frame.
        do_reset();
        for (int c = 0; c < 12; c++) send_col(16'h1234, 4'h5);
        tick();
        tick();
        chk("mid_trace_tb_en", tb_en, 1);
        reset = 1'b0;
        tick();
        chk("midrst_a_out", a_out, 16'hFFF0);
        chk("midrst_tb_en", tb_en, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_dx_valid", dx_valid, 0);
        reset = 1'b1;
        for (int c = 0; c < 11; c++) send_col(16'hFFF0, 4'h0);
        chk("midrst_fill11", {tb_en, in_ready}, 2'b01);
        push_zeros();
        send_col(16'hFFF0, 4'h0);
        frame_timing("midrst");

        // Sync error: minimum 12 must not trip, minimum 13 must, and it must stick.
        do_reset();
        for (int c = 0; c < 11; c++) send_col(16'hFFF0, 4'h0);
        push_zeros();
        send_col(16'hFFFC, 4'h0);
        chk("err_min12", error, 0);
        frame_timing("err_f1");
        for (int c = 0; c < 3; c++) send_col(16'hFFF0, 4'h0);
        push_zeros();
        send_col(16'hEFED, 4'h0);
        chk("err_min13", error, EXP_ERR);
        frame_timing("err_f2");
        chk("err_sticky", error, EXP_ERR);
        do_reset();
        chk("err_clear", error, 0);

        chk("sb_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/viterbi_tb_ctrl.md
# viterbi_tb_ctrl

Parametrised metric-update and traceback control unit for the Viterbi decoders. It generalises the fixed (2,1,3) controller to any constraint length, metric width, traceback depth and decode length. It holds the state metrics for an external ACS array, stores survivor decisions in a circular memory, and traces back from the best state. Decoded bits are emitted in chronological order, with optional metric normalisation and out-of-sync detection.

## Interface
- `K`, 3: constraint length; `S = 2**(K-1)` states.
- `W`, 4: state-metric width.
- `T`, 8: traceback depth (columns walked before decoding).
- `D`, 4: decode length (bits emitted per frame); memory depth `M = T + D`.
- `NFRAMES`, 64: frames per block before re-initialisation.
- `ERR_TH`, 12: minimum-metric threshold for the sync error.
- `clock`, in, 1: sole clock, rising edge.
- `reset`, in, 1: synchronous, active-low reset.
- `a_in`, in, `S*W`: new metrics from ACS; state i at `[i*W +: W]`.
- `p_in`, in, `S`: decision bit per state.
- `in_valid`, in, 1: `a_in`/`p_in` column valid.
- `in_ready`, out, 1: column accepted when `in_valid && in_ready`.
- `a_out`, out, `S*W`: registered current metrics to ACS.
- `tb_en`, out, 1: high during traceback.
- `dx`, out, 1: decoded bit.
- `dx_valid`, out, 1: `dx` qualifier.
- `error`, out, 1: sticky out-of-sync flag.

## Operation
- States:
  - FILL: accept columns.
  - TRACE: M cycles of traceback.
  - EMIT: D cycles of output.
- Init metrics are applied on reset and at block end: state 0 = 0, all others = `{W{1'b1}}`. Fill counter, write pointer and frame counter are cleared at the same points.
- FILL:
  - `in_ready=1`.
  - On accept, `a_out <= a_in` (normalised, see Configuration) and `mem[wr_ptr] <= p_in`.
  - `wr_ptr` increments modulo M, wrapping from M-1 to 0.
  - First frame of a block needs M accepted columns; each later frame needs D more.
- TRACE is entered on the cycle after the triggering accept.
  - Start state = index of the minimum `a_out`; on a tie, the lowest index wins.
  - Step i (0..M-1) reads column `wr_ptr-1-i` (mod M).
  - Predecessor = `{mem[col][s], s[K-2:1]}`; decoded bit of the column = `s[0]`.
  - Steps T..M-1 write `s[0]` into a D-bit output buffer.
- EMIT: buffer is shifted out oldest column first, one bit per cycle, with `dx_valid=1`.
- After EMIT:
  - Frame counter increments.
  - If it reaches NFRAMES, apply init metrics; otherwise return to FILL.
  - Trailing T columns of a block are never decoded; the upstream inserts a zero tail.
- Error: at TRACE entry, if the minimum metric > ERR_TH, `error <= 1`. It holds until reset.
- `in_valid` while `in_ready=0` is ignored; upstream holds data until accepted.
- Reset low in any state, including mid-TRACE/EMIT, returns every register to its reset value at the next edge. A partial frame is discarded.

## Timing
- Reset values:
  - `a_out` = init metrics.
  - `in_ready=1`.
  - `tb_en=0`, `dx=0`, `dx_valid=0`, `error=0`.
  - State = FILL.
- Accept-to-`a_out` latency: 1 cycle.
- Triggering accept at cycle n:
  - `in_ready=0` and `tb_en=1` for cycles n+1..n+M.
  - `dx_valid=1` for cycles n+M+1..n+M+D.
  - `in_ready=1` at cycle n+M+D+1.
- Per-frame throughput: D columns per (D accept cycles + M + D).
- `tb_en` and `dx_valid` are never high in the same cycle.

## Configuration
- `VTB_NORM_EN` defined:
  - On accept, if every metric in `a_in` has MSB=1, all metrics are stored with the MSB cleared (subtract `2**(W-1)`).
  - The ERR_TH comparison uses the normalised values.
- `VTB_NORM_EN` undefined: metrics are stored unmodified and wrap modulo `2**W`.

## Structure
- Shared package `viterbi_pkg` holds:
  - Functions for S and M.
  - Init-metric constant function.
  - FSM state enum (FILL, TRACE, EMIT).
- Sub-module `viterbi_min_state`: combinational log2(S)-level compare tree. Outputs the minimum index and value, lowest index on ties. Shared with the sync-error comparison.
- Survivor memory: M×S register array with pointer arithmetic modulo M.

## Test plan
All scenarios use K=3, W=4, T=8, D=4, M=12.
- Reset low 2 cycles → `a_out=16'hFFF0`, `in_ready=1`, `tb_en=0`, `dx_valid=0`, `error=0`.
- 12 columns with `p_in=0`, `a_in=16'hFFF0` → `tb_en` high for cycles 13..24, then `dx_valid` high 4 cycles with dx=0,0,0,0.
- Encoder-model stream for input 1,0,1,1,0,0,1,0,… (noiseless metrics) → first frame emits 1,0,1,1; the next 4 accepted columns produce the next 4 input bits.
- Accept `a_in={15,12,10,9}` (state 3..0):
  - with `VTB_NORM_EN`: `a_out={7,4,2,1}`;
  - without: `a_out={15,12,10,9}`.
- `in_valid` held high through TRACE/EMIT → no accept and `wr_ptr` unchanged; the column is accepted on the first FILL cycle. Reset pulsed mid-TRACE → reset values next cycle; the next frame needs 12 columns.
- Two further cases:
  - `NFRAMES=2`, after the second EMIT → `a_out=16'hFFF0`, and 12 columns are needed again.
  - Minimum metric 13 at TRACE entry → `error=1`, which stays high until reset.
